// File: rtl/game_pkg.sv
// Shared game types and constants: screen geometry, coordinate type,
// hit-detector state encoding and a helper for unsigned coordinate distance.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hit_state_t;

  // |a - b| widened to 11 bits so the distance never wraps
  function automatic logic [10:0] abs_diff(input coord_t a, input coord_t b);
    logic [10:0] wa;
    logic [10:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/hit_box_compare.sv
// Combinational box-overlap test between two centre points. The reach values
// are the summed half sizes of both objects; edges count as overlapping.
// Kept generic so wall collision tests can reuse it.
module hit_box_compare
  import game_pkg::*;
(
  input  coord_t      ax,
  input  coord_t      ay,
  input  coord_t      bx,
  input  coord_t      by,
  input  logic [10:0] reach_x,
  input  logic [10:0] reach_y,
  input  logic        active,
  output logic        overlap
);

  logic [10:0] dx;
  logic [10:0] dy;

  // distance along each axis, compared inclusively against the reach
  always_comb begin
    dx      = abs_diff(ax, bx);
    dy      = abs_diff(ay, by);
    overlap = active && (dx <= reach_x) && (dy <= reach_y);
  end

endmodule

// File: rtl/target_hit_detector.sv
// Target hit detector: tests the bullet against the target hit box once per
// frame, records hits, tracks health, drives the bullet retire handshake and
// the invulnerability blink.
// Optional build macro HIT_REGEN_EN: slow health regeneration while ALIVE.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  ALIVE  | target can be hit; regen counts here when enabled
//  INVULN | post-hit window, overlaps ignored, sprite blinks
//  DEAD   | health exhausted; waits for new_round
module target_hit_detector
  import game_pkg::*;
#(
  parameter int HEALTH_MAX    = 5,
  parameter int HIT_HALF_W    = 8,
  parameter int HIT_HALF_H    = 12,
  parameter int BULLET_SIZE   = 3,
  parameter int INVULN_FRAMES = 60,
`ifdef HIT_REGEN_EN
  parameter int BLINK_PERIOD  = 8,
  parameter int REGEN_FRAMES  = 300
`else
  parameter int BLINK_PERIOD  = 8
`endif
)(
  input  logic       frame_clk,
  input  logic       Reset,
  input  coord_t     TargetX,
  input  coord_t     TargetY,
  input  coord_t     BulletX,
  input  coord_t     BulletY,
  input  logic       bullet_active,
  input  logic       new_round,
  output logic       bullet_clear,
  output logic       hit_pulse,
  output logic [3:0] health,
  output logic       blink,
  output logic       dead
);

  localparam int          CNT_W    = $clog2(INVULN_FRAMES + 1);
  localparam logic [3:0]  HMAX     = 4'(HEALTH_MAX);
  localparam logic [10:0] REACH_X  = 11'(HIT_HALF_W + BULLET_SIZE);
  localparam logic [10:0] REACH_Y  = 11'(HIT_HALF_H + BULLET_SIZE);
  localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(INVULN_FRAMES - 1);

`ifdef HIT_REGEN_EN
  localparam int RCNT_W = $clog2(REGEN_FRAMES + 1);
  localparam logic [RCNT_W-1:0] REGEN_LAST = RCNT_W'(REGEN_FRAMES - 1);
  logic [RCNT_W-1:0] regen_cnt;
`endif

  hit_state_t       state;
  logic [CNT_W-1:0] inv_cnt;
  logic             overlap;
  logic             hit_cond;
  logic             blink_tick;

  hit_box_compare u_hit_box (
    .ax      (BulletX),
    .ay      (BulletY),
    .bx      (TargetX),
    .by      (TargetY),
    .reach_x (REACH_X),
    .reach_y (REACH_Y),
    .active  (bullet_active),
    .overlap (overlap)
  );

  // a hit needs a live target and no retire request still outstanding
  always_comb begin
    hit_cond   = overlap && (state == ALIVE) && !bullet_clear;
    blink_tick = ((32'(inv_cnt) % BLINK_PERIOD) == (BLINK_PERIOD - 1));
  end

  // state machine, health, invulnerability timer and retire handshake
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= ALIVE;
      health       <= HMAX;
      inv_cnt      <= '0;
      bullet_clear <= 1'b0;
      hit_pulse    <= 1'b0;
      blink        <= 1'b0;
      dead         <= 1'b0;
`ifdef HIT_REGEN_EN
      regen_cnt    <= '0;
`endif
    end else begin
      hit_pulse <= 1'b0;
`ifdef HIT_REGEN_EN
      regen_cnt <= '0;
`endif
      // the bullet block acknowledges retirement by dropping bullet_active
      if (bullet_clear && !bullet_active)
        bullet_clear <= 1'b0;

      if (new_round) begin
        // a round restart overrides any hit sampled in the same frame
        state   <= ALIVE;
        health  <= HMAX;
        inv_cnt <= '0;
        blink   <= 1'b0;
        dead    <= 1'b0;
      end else begin
        case (state)
          ALIVE: begin
            if (hit_cond) begin
              hit_pulse    <= 1'b1;
              bullet_clear <= 1'b1;
              inv_cnt      <= '0;
              if (health <= 4'd1) begin
                health <= 4'd0;
                state  <= DEAD;
                dead   <= 1'b1;
                blink  <= 1'b0;
              end else begin
                health <= health - 4'd1;
                state  <= INVULN;
              end
            end
`ifdef HIT_REGEN_EN
            else if (health < HMAX) begin
              if (regen_cnt == REGEN_LAST) begin
                health    <= health + 4'd1;
                regen_cnt <= '0;
              end else begin
                regen_cnt <= regen_cnt + 1'b1;
              end
            end
`endif
          end
          INVULN: begin
            if (inv_cnt == INV_LAST) begin
              state   <= ALIVE;
              inv_cnt <= '0;
              blink   <= 1'b0;
            end else begin
              inv_cnt <= inv_cnt + 1'b1;
              if (blink_tick)
                blink <= ~blink;
            end
          end
          DEAD: begin
            dead  <= 1'b1;
            blink <= 1'b0;
          end
          default: begin
            state <= ALIVE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_target_hit_detector.sv
// Directed bench for target_hit_detector: boundaries, hit handshake,
// invulnerability/blink timing, death, new_round, async reset, regen.
module tb_target_hit_detector;
  import game_pkg::*;

  logic       frame_clk;
  logic       Reset;
  coord_t     TargetX, TargetY, BulletX, BulletY;
  logic       bullet_active;
  logic       new_round;
  logic       bullet_clear;
  logic       hit_pulse;
  logic [3:0] health;
  logic       blink;
  logic       dead;

  int n_pass  = 0;
  int n_total = 0;

  target_hit_detector dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .TargetX       (TargetX),
    .TargetY       (TargetY),
    .BulletX       (BulletX),
    .BulletY       (BulletY),
    .bullet_active (bullet_active),
    .new_round     (new_round),
    .bullet_clear  (bullet_clear),
    .hit_pulse     (hit_pulse),
    .health        (health),
    .blink         (blink),
    .dead          (dead)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic put_bullet(input int x, input int y, input logic act);
    BulletX       = 10'(x);
    BulletY       = 10'(y);
    bullet_active = act;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge frame_clk);
    #1;
    n_total++; if (health !== 4'd5) $display("FAIL reset_health got=%0d exp=5", health); else n_pass++;
    n_total++; if (bullet_clear !== 1'b0) $display("FAIL reset_clear got=%0b exp=0", bullet_clear); else n_pass++;
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL reset_hit got=%0b exp=0", hit_pulse); else n_pass++;
    n_total++; if (blink !== 1'b0) $display("FAIL reset_blink got=%0b exp=0", blink); else n_pass++;
    n_total++; if (dead !== 1'b0) $display("FAIL reset_dead got=%0b exp=0", dead); else n_pass++;
    Reset = 1'b0;
    step();
  endtask

  task automatic test_boundary();
    put_bullet(332, 240, 1'b1); step();
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL bnd_dx12 got=%0b exp=0", hit_pulse); else n_pass++;
    put_bullet(320, 256, 1'b1); step();
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL bnd_dy16 got=%0b exp=0", hit_pulse); else n_pass++;
    put_bullet(308, 240, 1'b1); step();
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL bnd_dx12_left got=%0b exp=0", hit_pulse); else n_pass++;
    n_total++; if (health !== 4'd5) $display("FAIL bnd_health got=%0d exp=5", health); else n_pass++;
  endtask

  task automatic test_hit();
    put_bullet(331, 240, 1'b1); step();
    n_total++; if (hit_pulse !== 1'b1) $display("FAIL t1_hit got=%0b exp=1", hit_pulse); else n_pass++;
    n_total++; if (health !== 4'd4) $display("FAIL t1_health got=%0d exp=4", health); else n_pass++;
    n_total++; if (bullet_clear !== 1'b1) $display("FAIL t1_clear got=%0b exp=1", bullet_clear); else n_pass++;
  endtask

  task automatic test_invuln_hold();
    logic exp_blink;
    for (int k = 1; k <= 100; k++) begin
      step();
      exp_blink = (k < 60) ? logic'((k / 8) % 2) : 1'b0;
      n_total++; if (hit_pulse !== 1'b0) $display("FAIL hold_hit k=%0d got=%0b exp=0", k, hit_pulse); else n_pass++;
      n_total++; if (bullet_clear !== 1'b1) $display("FAIL hold_clear k=%0d got=%0b exp=1", k, bullet_clear); else n_pass++;
      n_total++; if (blink !== exp_blink) $display("FAIL hold_blink k=%0d got=%0b exp=%0b", k, blink, exp_blink); else n_pass++;
    end
    n_total++; if (health !== 4'd4) $display("FAIL hold_health got=%0d exp=4", health); else n_pass++;
    bullet_active = 1'b0; step();
    n_total++; if (bullet_clear !== 1'b0) $display("FAIL hold_release got=%0b exp=0", bullet_clear); else n_pass++;
  endtask

  task automatic test_invuln_ignore();
    put_bullet(320, 240, 1'b1); step();
    n_total++; if (health !== 4'd3) $display("FAIL ign_first got=%0d exp=3", health); else n_pass++;
    bullet_active = 1'b0; step();
    n_total++; if (bullet_clear !== 1'b0) $display("FAIL ign_clear got=%0b exp=0", bullet_clear); else n_pass++;
    bullet_active = 1'b1;
    for (int k = 2; k <= 60; k++) begin
      step();
      n_total++; if (hit_pulse !== 1'b0) $display("FAIL ign_hit k=%0d got=%0b exp=0", k, hit_pulse); else n_pass++;
    end
    step();
    n_total++; if (hit_pulse !== 1'b1) $display("FAIL ign_rehit got=%0b exp=1", hit_pulse); else n_pass++;
    n_total++; if (health !== 4'd2) $display("FAIL ign_health got=%0d exp=2", health); else n_pass++;
  endtask

  task automatic test_reset_mid_invuln();
    repeat (19) step();
    n_total++; if (bullet_clear !== 1'b1) $display("FAIL rst_pre_clear got=%0b exp=1", bullet_clear); else n_pass++;
    #2 Reset = 1'b1;
    #1;
    n_total++; if (bullet_clear !== 1'b0) $display("FAIL rst_clear got=%0b exp=0", bullet_clear); else n_pass++;
    n_total++; if (health !== 4'd5) $display("FAIL rst_health got=%0d exp=5", health); else n_pass++;
    n_total++; if (blink !== 1'b0) $display("FAIL rst_blink got=%0b exp=0", blink); else n_pass++;
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL rst_hit got=%0b exp=0", hit_pulse); else n_pass++;
    bullet_active = 1'b0;
    Reset = 1'b0;
    step();
  endtask

  task automatic test_inactive();
    put_bullet(320, 240, 1'b0);
    repeat (3) step();
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL inact_hit got=%0b exp=0", hit_pulse); else n_pass++;
    n_total++; if (health !== 4'd5) $display("FAIL inact_health got=%0d exp=5", health); else n_pass++;
  endtask

  task automatic test_dead();
    int px [5] = '{320, 309, 320, 331, 310};
    int py [5] = '{255, 240, 240, 252, 228};
    for (int i = 0; i < 5; i++) begin
      put_bullet(px[i], py[i], 1'b1); step();
      n_total++; if (hit_pulse !== 1'b1) $display("FAIL dead_hit i=%0d got=%0b exp=1", i, hit_pulse); else n_pass++;
      n_total++; if (health !== 4'(4 - i)) $display("FAIL dead_health i=%0d got=%0d exp=%0d", i, health, 4 - i); else n_pass++;
      n_total++; if (dead !== (i == 4)) $display("FAIL dead_flag i=%0d got=%0b exp=%0b", i, dead, (i == 4)); else n_pass++;
      bullet_active = 1'b0;
      if (i < 4) repeat (60) step();
    end
    n_total++; if (blink !== 1'b0) $display("FAIL dead_blink got=%0b exp=0", blink); else n_pass++;
    step();
    put_bullet(320, 240, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      n_total++; if (hit_pulse !== 1'b0 || health !== 4'd0 || dead !== 1'b1)
        $display("FAIL dead_ignore k=%0d got hit=%0b health=%0d dead=%0b exp 0/0/1", k, hit_pulse, health, dead);
      else n_pass++;
    end
    bullet_active = 1'b0; new_round = 1'b1; step();
    new_round = 1'b0;
    n_total++; if (health !== 4'd5) $display("FAIL nr_health got=%0d exp=5", health); else n_pass++;
    n_total++; if (dead !== 1'b0) $display("FAIL nr_dead got=%0b exp=0", dead); else n_pass++;
  endtask

  task automatic test_new_round_hit();
    put_bullet(320, 240, 1'b1); new_round = 1'b1; step();
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL nrhit_hit got=%0b exp=0", hit_pulse); else n_pass++;
    n_total++; if (bullet_clear !== 1'b0) $display("FAIL nrhit_clear got=%0b exp=0", bullet_clear); else n_pass++;
    new_round = 1'b0; step();
    n_total++; if (hit_pulse !== 1'b1) $display("FAIL nrhit_after got=%0b exp=1", hit_pulse); else n_pass++;
    bullet_active = 1'b0; new_round = 1'b1; step();
    n_total++; if (health !== 4'd5) $display("FAIL nr_invuln_health got=%0d exp=5", health); else n_pass++;
    new_round = 1'b0; bullet_active = 1'b1; step();
    n_total++; if (hit_pulse !== 1'b1) $display("FAIL nr_invuln_alive got=%0b exp=1", hit_pulse); else n_pass++;
    n_total++; if (health !== 4'd4) $display("FAIL nr_invuln_h4 got=%0d exp=4", health); else n_pass++;
  endtask

  task automatic test_regen();
    logic [3:0] h_exp;
`ifdef HIT_REGEN_EN
    h_exp = 4'd5;
`else
    h_exp = 4'd4;
`endif
    bullet_active = 1'b0;
    repeat (60) step();
    repeat (299) step();
    n_total++; if (health !== 4'd4) $display("FAIL regen_early got=%0d exp=4", health); else n_pass++;
    step();
    n_total++; if (health !== h_exp) $display("FAIL regen_full got=%0d exp=%0d", health, h_exp); else n_pass++;
    put_bullet(320, 240, 1'b1); step();
    h_exp = h_exp - 4'd1;
    n_total++; if (health !== h_exp) $display("FAIL regen_hit1 got=%0d exp=%0d", health, h_exp); else n_pass++;
    bullet_active = 1'b0;
    repeat (60) step();
    repeat (299) step();
    bullet_active = 1'b1; step();
    h_exp = h_exp - 4'd1;
    n_total++; if (hit_pulse !== 1'b1) $display("FAIL regen_hit299 got=%0b exp=1", hit_pulse); else n_pass++;
    n_total++; if (health !== h_exp) $display("FAIL regen_wins got=%0d exp=%0d", health, h_exp); else n_pass++;
    bullet_active = 1'b0;
    repeat (61) step();
    n_total++; if (health !== h_exp) $display("FAIL regen_restart got=%0d exp=%0d", health, h_exp); else n_pass++;
  endtask

  initial begin
    Reset = 1'b1;
    TargetX = 10'd320;
    TargetY = 10'd240;
    put_bullet(0, 0, 1'b0);
    new_round = 1'b0;
    test_reset();
    test_boundary();
    test_hit();
    test_invuln_hold();
    test_invuln_ignore();
    test_reset_mid_invuln();
    test_inactive();
    test_dead();
    test_new_round_hit();
    test_regen();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
